pipe_skid_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_skid_reg_if.sv | 42 ++++
 rtl/pipe_skid_reg_slot.sv | 43 ++++
 rtl/pipe_skid_reg.sv | 124 ++++++++++++
 tb/tb_pipe_skid_reg.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared constants for the pipeline stage registers of the core datapath.
//   XLEN          - native lane width of the datapath
//   *_LANES       - number of lanes carried by each named stage register
//   lane_lsb(k,w) - bit offset of lane k inside a packed bundle of w-bit lanes
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int XLEN        = 32;
    localparam int IFID_LANES  = 2;
    localparam int IDEX_LANES  = 3;
    localparam int EXMEM_LANES = 2;
    localparam int MEMWB_LANES = 2;

    // Lane k of a bundle occupies bits [k*w +: w].
    function automatic int lane_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg_if
// Valid/ready handshake bundle around one pipeline stage register.
//   in_valid  / in_data  / in_ready   - upstream side of the stage
//   out_valid / out_data / out_ready  - downstream side of the stage
// Modports:
//   master - the surrounding pipeline (drives in_*, out_ready)
//   slave  - the stage register itself (drives in_ready, out_*)
// ---------------------------------------------------------------------------
interface pipe_skid_reg_if
    import pipe_pkg::*;
#(
    parameter int W     = XLEN,
    parameter int LANES = IFID_LANES
);

    logic               in_valid;
    logic [LANES*W-1:0] in_data;
    logic               in_ready;
    logic               out_valid;
    logic [LANES*W-1:0] out_data;
    logic               out_ready;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/pipe_skid_reg_slot.sv
// ---------------------------------------------------------------------------
// pipe_slot
// One storage slot of the stage register: a data flop plus its valid flag.
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - synchronous clear: valid and data go to zero
//   load      - capture loadData and mark the slot valid
//   drop      - mark the slot empty, data keeps its last value
//   loadData  - value captured on load
//   valid     - slot holds a live bundle
//   data      - slot contents
// Priority: rst > clear > load > drop.
// ---------------------------------------------------------------------------
module pipe_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             drop,
    input  logic [WIDTH-1:0] loadData,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Data only changes on reset, clear or load; a drop just retires the
    // valid flag so the last bundle stays visible on the data lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= loadData;
        end else if (drop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
// Pipeline stage register with valid/ready handshake and a 2-entry skid
// buffer. LANES opaque lanes of W bits travel together as one bundle.
//   clk    - clock, all updates on the rising edge
//   rst    - asynchronous active-high reset, empties both slots
//   flush  - synchronous clear of both slots; a same-cycle input is dropped
//   bus    - slave side of pipe_skid_reg_if:
//              in_valid/in_data/in_ready    upstream handshake
//              out_valid/out_data/out_ready downstream handshake
// in_ready comes straight from a flop, so back-pressure never forms a
// combinational path from out_ready back to the upstream stage.
// ---------------------------------------------------------------------------
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int W     = XLEN,
    parameter int LANES = IFID_LANES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    pipe_skid_reg_if.slave   bus
);

    localparam int BW = LANES * W;

    logic          mainValid;
    logic [BW-1:0] mainData;
    logic          skidValid;
    logic [BW-1:0] skidData;
    logic          inReadyQ;

    logic          inFire;
    logic          outFire;
    logic          mainFree;

    logic          mainLoad;
    logic          mainDrop;
    logic [BW-1:0] mainSrc;
    logic          skidLoad;
    logic          skidDrop;
    logic          skidValidNext;

    assign inFire   = bus.in_valid & inReadyQ;
    assign outFire  = mainValid & bus.out_ready;
    assign mainFree = ~mainValid | outFire;

    // Slot steering. When the main slot frees up, the skid entry (if any)
    // moves forward first to keep FIFO order; otherwise a new bundle goes
    // straight to main. A held main slot pushes new arrivals into skid.
    // With skid occupied in_ready is low, so inFire cannot coincide with the
    // skid-to-main move and skid simply empties.
    always_comb begin
        mainLoad = 1'b0;
        mainDrop = 1'b0;
        mainSrc  = bus.in_data;
        skidLoad = 1'b0;
        skidDrop = 1'b0;
        if (mainFree) begin
            if (skidValid) begin
                mainLoad = 1'b1;
                mainSrc  = skidData;
                skidDrop = 1'b1;
            end else if (inFire) begin
                mainLoad = 1'b1;
            end else begin
                mainDrop = 1'b1;
            end
        end else if (inFire) begin
            skidLoad = 1'b1;
        end
    end

    // Next value of the skid flag, used to precompute in_ready so that the
    // port can be driven by a dedicated flop.
    always_comb begin
        skidValidNext = skidValid;
        if (skidLoad) begin
            skidValidNext = 1'b1;
        end else if (skidDrop) begin
            skidValidNext = 1'b0;
        end
    end

    // in_ready mirrors ~skid_valid one-for-one; reset and flush both leave
    // the skid empty, so the stage is ready right away in both cases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inReadyQ <= 1'b1;
        end else if (flush) begin
            inReadyQ <= 1'b1;
        end else begin
            inReadyQ <= ~skidValidNext;
        end
    end

    pipe_slot #(.WIDTH(BW)) u_main (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush),
        .load     (mainLoad),
        .drop     (mainDrop),
        .loadData (mainSrc),
        .valid    (mainValid),
        .data     (mainData)
    );

    pipe_slot #(.WIDTH(BW)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush),
        .load     (skidLoad),
        .drop     (skidDrop),
        .loadData (bus.in_data),
        .valid    (skidValid),
        .data     (skidData)
    );

    assign bus.in_ready  = inReadyQ;
    assign bus.out_valid = mainValid;
    assign bus.out_data  = mainData;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_reg
// Drives three pipe_skid_reg instances (W=32/LANES=2, W=8/LANES=3,
// W=1/LANES=1) from one shared handshake and one 64-bit data source, and
// compares all of them against a queue-based reference of the stage.
// ---------------------------------------------------------------------------
module tb_pipe_skid_reg;
    import pipe_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        inValid;
    logic        outReady;
    logic [63:0] dataIn;

    int testCount = 0;
    int failCount = 0;

    // Reference: the stage is a FIFO of at most two bundles; lastOut is what
    // the output shows when the FIFO is empty.
    logic [63:0] q[$];
    logic [63:0] lastOut;

    pipe_skid_reg_if #(.W(32), .LANES(2)) ifA ();
    pipe_skid_reg_if #(.W(8),  .LANES(3)) ifB ();
    pipe_skid_reg_if #(.W(1),  .LANES(1)) ifC ();

    assign ifA.in_valid  = inValid;
    assign ifA.in_data   = dataIn;
    assign ifA.out_ready = outReady;
    assign ifB.in_valid  = inValid;
    assign ifB.in_data   = dataIn[23:0];
    assign ifB.out_ready = outReady;
    assign ifC.in_valid  = inValid;
    assign ifC.in_data   = dataIn[0:0];
    assign ifC.out_ready = outReady;

    pipe_skid_reg #(.W(32), .LANES(2)) dutA (.clk(clk), .rst(rst), .flush(flush), .bus(ifA));
    pipe_skid_reg #(.W(8),  .LANES(3)) dutB (.clk(clk), .rst(rst), .flush(flush), .bus(ifB));
    pipe_skid_reg #(.W(1),  .LANES(1)) dutC (.clk(clk), .rst(rst), .flush(flush), .bus(ifC));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        q.delete();
        lastOut = '0;
    endtask

    // One clock edge of the reference, using the inputs held during the cycle.
    task automatic modelEdge();
        int  sz;
        bit  doPop;
        bit  doPush;
        sz     = q.size();
        doPop  = (sz > 0) && outReady;
        doPush = inValid && (sz < 2);
        if (flush) begin
            q.delete();
            lastOut = '0;
        end else begin
            if (doPop) lastOut = q.pop_front();
            if (doPush) q.push_back(dataIn);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [63:0] expData;
        logic        expValid;
        logic        expReady;
        expValid = (q.size() > 0);
        expData  = expValid ? q[0] : lastOut;
        expReady = (q.size() < 2);
        cmp({tag, " A.out_valid"}, 64'(ifA.out_valid), 64'(expValid));
        cmp({tag, " A.out_data"},  ifA.out_data, expData);
        cmp({tag, " A.in_ready"},  64'(ifA.in_ready), 64'(expReady));
        cmp({tag, " B.out_valid"}, 64'(ifB.out_valid), 64'(expValid));
        cmp({tag, " B.out_data"},  64'(ifB.out_data), 64'(expData[23:0]));
        cmp({tag, " B.in_ready"},  64'(ifB.in_ready), 64'(expReady));
        cmp({tag, " C.out_valid"}, 64'(ifC.out_valid), 64'(expValid));
        cmp({tag, " C.out_data"},  64'(ifC.out_data), 64'(expData[0]));
        cmp({tag, " C.in_ready"},  64'(ifC.in_ready), 64'(expReady));
    endtask

    task automatic applyStimulus(input logic iv, input logic [63:0] d,
                                 input logic ordy, input logic fl, input string tag);
        inValid  = iv;
        dataIn   = d;
        outReady = ordy;
        flush    = fl;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput(tag);
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        logic [31:0] laneVal;

        inValid  = 1'b0;
        outReady = 1'b0;
        flush    = 1'b0;
        dataIn   = '0;
        rst      = 1'b1;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("reset");
        rst = 1'b0;

        // Streaming: back-to-back bundles, each visible one cycle later.
        applyStimulus(1'b1, {32'h22, 32'h11}, 1'b1, 1'b0, "stream0");
        laneVal = ifA.out_data[lane_lsb(1, 32) +: 32];
        cmp("stream0 lane1", 64'(laneVal), 64'h22);
        applyStimulus(1'b1, {32'h44, 32'h33}, 1'b1, 1'b0, "stream1");
        laneVal = ifA.out_data[lane_lsb(0, 32) +: 32];
        cmp("stream1 lane0", 64'(laneVal), 64'h33);
        applyStimulus(1'b1, {32'h66, 32'h55}, 1'b1, 1'b0, "stream2");
        cmp("stream2 data", ifA.out_data, 64'h0000_0066_0000_0055);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, "streamIdle");
        cmp("streamIdle hold", ifA.out_data, 64'h0000_0066_0000_0055);

        // Stall fill: A held on output, B into skid, in_ready drops.
        a = 64'hAAAA_0001_5555_0001;
        b = 64'hBBBB_0002_4444_0000;
        applyStimulus(1'b1, a, 1'b0, 1'b0, "stallA");
        applyStimulus(1'b1, b, 1'b0, 1'b0, "stallB");
        cmp("stallB ready low", 64'(ifA.in_ready), 64'h0);
        applyStimulus(1'b1, 64'hDEAD, 1'b0, 1'b0, "stallFull");
        cmp("stallFull hold A", ifA.out_data, a);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, "release1");
        cmp("release1 shows B", ifA.out_data, b);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, "release2");

        // Flush with both slots full and an input offered that same cycle.
        applyStimulus(1'b1, 64'h1111, 1'b0, 1'b0, "flushFill1");
        applyStimulus(1'b1, 64'h2222, 1'b0, 1'b0, "flushFill2");
        applyStimulus(1'b1, 64'hC0C0, 1'b0, 1'b1, "flush");
        cmp("flush out_data zero", ifA.out_data, 64'h0);
        cmp("flush ready", 64'(ifA.in_ready), 64'h1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, "postFlush1");
        applyStimulus(1'b0, '0, 1'b1, 1'b0, "postFlush2");

        // Asynchronous reset in the middle of a stalled stream.
        applyStimulus(1'b1, 64'h7777_0000_8888_0001, 1'b0, 1'b0, "preRst1");
        applyStimulus(1'b1, 64'h9999_0000_6666_0001, 1'b0, 1'b0, "preRst2");
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("asyncRst");
        @(negedge clk);
        checkOutput("rstHeld");
        rst = 1'b0;
        applyStimulus(1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, "afterRst");
        cmp("afterRst data", ifA.out_data, 64'h0123_4567_89AB_CDEF);

        // Random traffic, ~2% flush; in_ready is also probed with out_ready
        // toggled mid-cycle to show it has no combinational dependence on it.
        for (int i = 0; i < 10000; i++) begin
            inValid  = ($urandom_range(0, 99) < 60);
            outReady = ($urandom_range(0, 99) < 55);
            flush    = ($urandom_range(0, 99) < 2);
            dataIn   = {$urandom, $urandom};
            #1;
            outReady = ~outReady;
            #1;
            cmp("rand combReady", 64'(ifA.in_ready), 64'(q.size() < 2));
            outReady = ~outReady;
            @(posedge clk);
            modelEdge();
            @(negedge clk);
            checkOutput("rand");
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
